// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing with frame-synchronous image select.
// Optional macro VGA_PIX_DIV_EN: derive the pixel tick from a 2x clk via an internal divider.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       img_sel,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       frame_start,
  output logic       CHG_IMG
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       tick;
  logic       line_end;
  logic       frame_end;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       von_q, von_d;
  logic       fs_q, fs_d;
  logic       chg_q, chg_d;
  logic [1:0] sync_q;

`ifdef VGA_PIX_DIV_EN
  logic div_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
    end
  end

  assign tick = div_q;
`else
  assign tick = rst_n;
`endif

  assign pix_tick = tick;

  // Sync/visible flags decode the next-state counters so they line up with pos_x/pos_y.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    line_end  = (x_q == H_LAST);
    frame_end = line_end && (y_q == V_LAST);
    if (tick) begin
      if (line_end) begin
        x_d = 10'd0;
        y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hs_d  = !((x_d >= HS_START) && (x_d < HS_END));
    vs_d  = !((y_d >= VS_START) && (y_d < VS_END));
    von_d = (x_d < H_VIS_END) && (y_d < V_VIS_END);
    fs_d  = tick && frame_end;
    chg_d = fs_d ? sync_q[1] : chg_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= 10'd0;
      y_q    <= 10'd0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      von_q  <= 1'b1;
      fs_q   <= 1'b0;
      chg_q  <= 1'b0;
      sync_q <= 2'b00;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      von_q  <= von_d;
      fs_q   <= fs_d;
      chg_q  <= chg_d;
      sync_q <= {sync_q[0], img_sel};
    end
  end

  assign pos_x       = x_q;
  assign pos_y       = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = von_q;
  assign frame_start = fs_q;
  assign CHG_IMG     = chg_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench: full-size and shrunk-raster DUTs against a tick-count model.
module tb_vga_timing_gen;

`ifdef VGA_PIX_DIV_EN
  localparam int CPT = 2;
  localparam bit DIV = 1'b1;
`else
  localparam int CPT = 1;
  localparam bit DIV = 1'b0;
`endif

  localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 4;
  localparam int SVV = 48, SVF = 2, SVS = 2, SVB = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic img_sel;

  logic       f_tick, f_hs, f_vs, f_von, f_fs, f_chg;
  logic [9:0] f_x, f_y;
  logic       s_tick, s_hs, s_vs, s_von, s_fs, s_chg;
  logic [9:0] s_x, s_y;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_f (
    .clk(clk), .rst_n(rst_n), .img_sel(img_sel),
    .pix_tick(f_tick), .hsync(f_hs), .vsync(f_vs), .video_on(f_von),
    .pos_x(f_x), .pos_y(f_y), .frame_start(f_fs), .CHG_IMG(f_chg)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .img_sel(img_sel),
    .pix_tick(s_tick), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .pos_x(s_x), .pos_y(s_y), .frame_start(s_fs), .CHG_IMG(s_chg)
  );

  function automatic int hv(int i); return (i == 1) ? SHV : 640; endfunction
  function automatic int hf(int i); return (i == 1) ? SHF : 16;  endfunction
  function automatic int hs(int i); return (i == 1) ? SHS : 96;  endfunction
  function automatic int hb(int i); return (i == 1) ? SHB : 48;  endfunction
  function automatic int vv(int i); return (i == 1) ? SVV : 480; endfunction
  function automatic int vf(int i); return (i == 1) ? SVF : 10;  endfunction
  function automatic int vs(int i); return (i == 1) ? SVS : 2;   endfunction
  function automatic int vb(int i); return (i == 1) ? SVB : 33;  endfunction
  function automatic int ht(int i); return hv(i) + hf(i) + hs(i) + hb(i); endfunction
  function automatic int vt(int i); return vv(i) + vf(i) + vs(i) + vb(i); endfunction

  // Model: each raster is just a tick index within the frame; img history is the raw input samples.
  int n [2];
  bit m_chg [2];
  bit m_fs [2];
  bit m_div;
  bit img_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_edge();
    bit tk;
    bit seen;
    bit wrap;
    int ft;
    if (!rst_n) begin
      m_div = 1'b0;
      img_q.delete();
      for (int i = 0; i < 2; i++) begin
        n[i] = 0; m_chg[i] = 1'b0; m_fs[i] = 1'b0;
      end
    end else begin
      tk   = DIV ? m_div : 1'b1;
      seen = (img_q.size() >= 2) ? img_q[img_q.size() - 2] : 1'b0;
      m_div = !m_div;
      for (int i = 0; i < 2; i++) begin
        ft   = ht(i) * vt(i);
        wrap = tk && (n[i] == ft - 1);
        m_fs[i] = wrap;
        if (wrap) m_chg[i] = seen;
        if (tk) n[i] = (n[i] + 1) % ft;
      end
      img_q.push_back(img_sel);
      if (img_q.size() > 3) void'(img_q.pop_front());
    end
  endtask

  task automatic check_inst(input int i, input logic tk, input logic h, input logic v,
                            input logic von, input logic [9:0] x, input logic [9:0] y,
                            input logic fs, input logic chg);
    int ex, ey;
    string p;
    p  = (i == 1) ? "s" : "f";
    ex = n[i] % ht(i);
    ey = n[i] / ht(i);
    chk({p, "_x"}, 32'(x), 32'(ex));
    chk({p, "_y"}, 32'(y), 32'(ey));
    chk({p, "_hsync"}, 32'(h), 32'(!(ex >= hv(i) + hf(i) && ex < hv(i) + hf(i) + hs(i))));
    chk({p, "_vsync"}, 32'(v), 32'(!(ey >= vv(i) + vf(i) && ey < vv(i) + vf(i) + vs(i))));
    chk({p, "_video_on"}, 32'(von), 32'(ex < hv(i) && ey < vv(i)));
    chk({p, "_frame_start"}, 32'(fs), 32'(m_fs[i]));
    chk({p, "_chg_img"}, 32'(chg), 32'(m_chg[i]));
    chk({p, "_pix_tick"}, 32'(tk), 32'(!rst_n ? 1'b0 : (DIV ? m_div : 1'b1)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_inst(0, f_tick, f_hs, f_vs, f_von, f_x, f_y, f_fs, f_chg);
    check_inst(1, s_tick, s_hs, s_vs, s_von, s_x, s_y, s_fs, s_chg);
  endtask

  task automatic wait_small_pos(input int x, input int y);
    int k;
    for (k = 0; k < 3 * SHV * SVV * 2 * CPT; k++) begin
      if (s_x == 10'(x) && s_y == 10'(y)) break;
      step();
    end
    if (!(s_x == 10'(x) && s_y == 10'(y))) chk("timeout_pos", 32'(k), 32'(0));
  endtask

  task automatic wait_small_fs();
    int k;
    for (k = 0; k < 2 * 80 * 55 * CPT; k++) begin
      step();
      if (s_fs) break;
    end
    if (!s_fs) chk("timeout_fs", 32'(k), 32'(0));
  endtask

  int  hs_low, cnt, vs_cnt, von_cnt, fs_cnt;
  bit  wrap_seen, last_chg, prev_von;
  logic [9:0] prev_x;

  initial begin
    rst_n = 1'b0;
    img_sel = 1'b0;
    repeat (3) step();
    chk("rst_x", 32'(f_x), 32'd0);
    chk("rst_y", 32'(f_y), 32'd0);
    chk("rst_syncs", 32'({f_hs, f_vs}), 32'd3);
    chk("rst_video_on", 32'(f_von), 32'd1);
    chk("rst_chg", 32'(f_chg), 32'd0);
    chk("rst_fs", 32'(f_fs), 32'd0);

    rst_n = 1'b1;
    repeat (CPT - 1) begin
      step();
      chk("pre_advance_x", 32'(f_x), 32'd0);
    end
    step();
    chk("first_advance_x", 32'(f_x), 32'd1);

    hs_low = 0;
    wrap_seen = 1'b0;
    for (int k = 0; k < 2 * 800 * CPT; k++) begin
      prev_x = f_x;
      prev_von = f_von;
      step();
      if (!f_hs) hs_low++;
      if (prev_von && !f_von) begin
        chk("von_fall_x", 32'(f_x), 32'd640);
        chk("von_fall_prev_x", 32'(prev_x), 32'd639);
      end
      if (prev_x == 10'd799 && f_x == 10'd0) begin
        chk("line_wrap_y", 32'(f_y), 32'd1);
        wrap_seen = 1'b1;
        break;
      end
    end
    chk("line_wrap_seen", 32'(wrap_seen), 32'd1);
    chk("hsync_low_clks", 32'(hs_low), 32'(96 * CPT));

    wait_small_fs();
    cnt = 1; fs_cnt = 1; von_cnt = s_von ? 1 : 0; vs_cnt = s_vs ? 0 : 1;
    for (int k = 0; k < 2 * 80 * 55 * CPT; k++) begin
      step();
      if (s_fs) break;
      cnt++;
      if (s_von) von_cnt++;
      if (!s_vs) vs_cnt++;
    end
    chk("frame_len_clks", 32'(cnt), 32'(80 * 55 * CPT));
    chk("frame_fs_count", 32'(fs_cnt), 32'd1);
    chk("vsync_low_clks", 32'(vs_cnt), 32'(SVS * 80 * CPT));
    chk("video_on_clks", 32'(von_cnt), 32'(SHV * SVV * CPT));

    wait_small_pos(10, 20);
    img_sel = 1'b1;
    last_chg = s_chg;
    for (int k = 0; k < 2 * 80 * 55 * CPT; k++) begin
      last_chg = s_chg;
      step();
      if (s_fs) break;
    end
    chk("chg_before_wrap", 32'(last_chg), 32'd0);
    chk("chg_at_wrap", 32'(s_chg), 32'd1);
    chk("chg_with_fs", 32'(s_fs), 32'd1);

    wait_small_pos(10, 20);
    img_sel = 1'b0;
    repeat (50) step();
    img_sel = 1'b1;
    wait_small_fs();
    chk("chg_after_pulse", 32'(s_chg), 32'd1);

    for (int k = 0; k < 2 * 80 * 55 * CPT; k++) begin
      if ($urandom_range(0, 599) == 0) img_sel = ~img_sel;
      step();
    end
    img_sel = 1'b1;

    wait_small_pos(70, 51);
    chk("pre_rst_hsync", 32'(s_hs), 32'd0);
    chk("pre_rst_vsync", 32'(s_vs), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_x", 32'(s_x), 32'd0);
    chk("mrst_y", 32'(s_y), 32'd0);
    chk("mrst_syncs", 32'({s_hs, s_vs}), 32'd3);
    chk("mrst_chg", 32'(s_chg), 32'd0);
    repeat (20 * CPT) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing: horizontal/vertical counters, active-low sync pulses, a visible-area flag and the current pixel position. Drives `pos_x`/`pos_y`/`CHG_IMG` into the pixel-position-to-address stage, which turns them into frame-buffer read addresses. Also registers the image-select switch and applies it only at frame boundaries, so a displayed frame never mixes encrypted and decrypted images.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixel ticks)
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width
- `V_BP`, 33, vertical back porch
- `clk`  in  1  system clock; sole clock
- `rst_n`  in  1  synchronous, active-low reset
- `img_sel`  in  1  asynchronous image-select switch level
- `pix_tick`  out  1  pixel-advance strobe, one `clk` wide
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `video_on`  out  1  high while (`pos_x`,`pos_y`) is in the visible area
- `pos_x`  out  10  horizontal counter, 0..H_TOTAL-1
- `pos_y`  out  10  vertical counter, 0..V_TOTAL-1
- `frame_start`  out  1  one-`clk` pulse when counters wrap to (0,0)
- `CHG_IMG`  out  1  frame-stable image select (1 = decrypted 320-wide, 0 = encrypted 640-wide)

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 1024.
- On each `clk` edge with `pix_tick`=1:
  - `pos_x` increments. At H_TOTAL-1 it wraps to 0.
  - When `pos_x` wraps, `pos_y` increments. At V_TOTAL-1 it wraps to 0.
- `hsync`=0 iff H_VISIBLE+H_FP ≤ `pos_x` < H_VISIBLE+H_FP+H_SYNC (656..751).
- `vsync`=0 iff V_VISIBLE+V_FP ≤ `pos_y` < V_VISIBLE+V_FP+V_SYNC (490..491).
- `video_on`=1 iff `pos_x` < H_VISIBLE and `pos_y` < V_VISIBLE.
- `hsync`, `vsync`, `video_on` are registered from next-state counter values. They are therefore always consistent with `pos_x`/`pos_y` in the same cycle, and glitch-free.
- `img_sel` passes through a 2-flop synchronizer.
- `CHG_IMG` loads the synchronized value only on the edge where counters wrap to (0,0). `frame_start` is asserted in the cycle following that edge. The synchronized value is ignored at all other times.
- No state machine beyond the counters. Counter phase (visible/FP/sync/BP) is a pure decode.

## Timing
- Reset (edge with `rst_n`=0) sets:
  - `pos_x`=0, `pos_y`=0
  - `hsync`=1, `vsync`=1, `video_on`=1 (consistent with position (0,0))
  - `frame_start`=0, `CHG_IMG`=0
  - synchronizer flops=0, divider=0
  - `pix_tick`=0 when the divider is compiled in
- Reset mid-frame returns to the state above on that edge. No partial line or frame completes.
- `frame_start` is not asserted out of reset. The first pulse occurs at the first wrap.
- `img_sel` to `CHG_IMG` latency: 2 `clk` of synchronization, then wait for the next wrap edge. Worst case is one full frame plus 2 clk.
- A toggle of `img_sel` that reverts before the next wrap has no effect on `CHG_IMG`.
- When the sync and wrap edges coincide, the value sampled at that edge is the one loaded.

## Configuration
- `VGA_PIX_DIV_EN` defined:
  - `clk` is 50 MHz.
  - An internal toggle flop produces `pix_tick` on every second `clk`, starting with the second edge after reset release.
  - Line = 1600 clk. Frame = 840000 clk.
- `VGA_PIX_DIV_EN` undefined:
  - `clk` is the 25 MHz pixel clock.
  - `pix_tick` is tied to 1 (0 while in reset).
  - Line = 800 clk. Frame = 420000 clk.

## Test plan
- Reset check: hold `rst_n`=0 for 3 clk, release. Required: `pos`=(0,0), `hsync`=`vsync`=1, `video_on`=1, `CHG_IMG`=0, `frame_start`=0. First advance to `pos_x`=1 comes after 1 tick (2 clk with `VGA_PIX_DIV_EN`).
- Line timing: run one line.
  - `hsync` low exactly for `pos_x` 656..751 (96 ticks).
  - `video_on` falls when `pos_x` goes 639→640.
  - `pos_x` wraps 799→0 and `pos_y` increments 0→1 on the same edge.
- Frame timing: run 420000 ticks.
  - `vsync` low exactly for `pos_y` 490..491 (1600 ticks).
  - `frame_start` pulses exactly once, at (0,0).
  - `video_on` is high for exactly 307200 ticks.
- Image select: set `img_sel`=1 at `pos`=(100,200). Required: `CHG_IMG` stays 0 until the wrap to (0,0), then reads 1 together with `frame_start`. A 50-clk pulse on `img_sel` mid-frame leaves `CHG_IMG` unchanged.
- Mid-frame reset: assert `rst_n`=0 for 1 clk at `pos`=(700,491), while `hsync`=`vsync`=0. Required: the next cycle shows `pos`=(0,0), syncs=1, `CHG_IMG`=0.
